// File: rtl/det_stat_window_if.sv
// -----------------------------------------------------------------------------
// det_stat_window_if
// Bundles the control, detector-facing and readout signals of det_stat_window.
//   slave  modport : the det_stat_window block itself
//   master modport : the environment (sequencer/host and the detector)
// Signals:
//   enable      run windows back-to-back while high
//   clear       synchronous clear of counters and FSM
//   det_in      detect flag from the detector
//   det_rst_n   active-low synchronous reset driven to the detector
//   busy        FSM not idle
//   win_done    one-cycle pulse when a window's result is committed
//   win_hit     result of the last completed window
//   trial_count completed windows
//   hit_count   windows with at least one qualifying detection
//   sat         sticky, trial_count reached all-ones
//   first_idx   idx of first qualifying detection (DET_STAT_FIRST_IDX_EN only)
// -----------------------------------------------------------------------------
interface det_stat_window_if #(
    parameter int CNT_W = 32
`ifdef DET_STAT_FIRST_IDX_EN
    , parameter int IDX_W = 4
`endif
);
    logic             enable;
    logic             clear;
    logic             det_in;
    logic             det_rst_n;
    logic             busy;
    logic             win_done;
    logic             win_hit;
    logic [CNT_W-1:0] trial_count;
    logic [CNT_W-1:0] hit_count;
    logic             sat;
`ifdef DET_STAT_FIRST_IDX_EN
    logic [IDX_W-1:0] first_idx;
`endif

    modport slave (
        input  enable, clear, det_in,
`ifdef DET_STAT_FIRST_IDX_EN
        output first_idx,
`endif
        output det_rst_n, busy, win_done, win_hit, trial_count, hit_count, sat
    );

    modport master (
        output enable, clear, det_in,
`ifdef DET_STAT_FIRST_IDX_EN
        input  first_idx,
`endif
        input  det_rst_n, busy, win_done, win_hit, trial_count, hit_count, sat
    );
endinterface

// File: rtl/det_stat_window.sv
// -----------------------------------------------------------------------------
// det_stat_window
// Measures per-trial detection probability of a sequence detector. Each trial
// holds the detector in reset for one cycle (ARM), observes det_in for WIN_LEN
// cycles (RUN, idx 1..WIN_LEN), then commits one result (DONE). A window is a
// hit if det_in was high at least once with idx >= MIN_IDX.
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    det_stat_window_if.slave (enable, clear, det_in in;
//          det_rst_n, busy, win_done, win_hit, trial_count, hit_count, sat out)
//
// Timing: win_done is high during the DONE cycle; win_hit, the counters and
// sat take their new values at the edge that ends DONE.
// Saturation: once trial_count becomes all-ones the FSM parks in IDLE and both
// counters freeze until clear or reset, keeping hit_count/trial_count valid.
//
// Optional feature macro: DET_STAT_FIRST_IDX_EN adds bus.first_idx, the idx of
// the first qualifying detection of the last committed window (0 if none).
// -----------------------------------------------------------------------------
module det_stat_window #(
    parameter int WIN_LEN = 9,
    parameter int MIN_IDX = 5,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    det_stat_window_if.slave bus
);
    localparam int IDX_W = $clog2(WIN_LEN + 1);

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_MIN  = IDX_W'(MIN_IDX);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             hit_flag_q, hit_flag_d;
    logic [CNT_W-1:0] trial_q, trial_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [CNT_W-1:0] trial_inc_s;
    logic             win_hit_q, win_hit_d;
    logic             sat_q, sat_d;
    logic             det_rst_n_q, det_rst_n_d;
    logic             busy_q, busy_d;
    logic             win_done_q, win_done_d;
    logic             qual_s;
`ifdef DET_STAT_FIRST_IDX_EN
    logic [IDX_W-1:0] first_q, first_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;
`endif

    // A detection only counts from MIN_IDX onward in the window.
    assign qual_s = bus.det_in && (idx_q >= IDX_MIN);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            hit_flag_q  <= 1'b0;
            trial_q     <= '0;
            hits_q      <= '0;
            win_hit_q   <= 1'b0;
            sat_q       <= 1'b0;
`ifdef DET_STAT_FIRST_IDX_EN
            first_q     <= '0;
            first_idx_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hit_flag_q  <= hit_flag_d;
            trial_q     <= trial_d;
            hits_q      <= hits_d;
            win_hit_q   <= win_hit_d;
            sat_q       <= sat_d;
`ifdef DET_STAT_FIRST_IDX_EN
            first_q     <= first_d;
            first_idx_q <= first_idx_d;
`endif
        end
    end

    // Next-state and datapath update; clear overrides everything.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hit_flag_d  = hit_flag_q;
        trial_d     = trial_q;
        hits_d      = hits_q;
        win_hit_d   = win_hit_q;
        sat_d       = sat_q;
        trial_inc_s = trial_q + CNT_ONE;
`ifdef DET_STAT_FIRST_IDX_EN
        first_d     = first_q;
        first_idx_d = first_idx_q;
`endif
        if (bus.clear) begin
            state_d    = S_IDLE;
            idx_d      = '0;
            hit_flag_d = 1'b0;
            trial_d    = '0;
            hits_d     = '0;
            win_hit_d  = 1'b0;
            sat_d      = 1'b0;
`ifdef DET_STAT_FIRST_IDX_EN
            first_d     = '0;
            first_idx_d = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.enable && !sat_q) begin
                        state_d = S_ARM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ARM: begin
                    idx_d      = IDX_ONE;
                    hit_flag_d = 1'b0;
`ifdef DET_STAT_FIRST_IDX_EN
                    first_d    = '0;
`endif
                    state_d    = S_RUN;
                end
                S_RUN: begin
                    if (qual_s) begin
                        hit_flag_d = 1'b1;
`ifdef DET_STAT_FIRST_IDX_EN
                        // Only the first qualifying idx of the window is kept.
                        if (!hit_flag_q) begin
                            first_d = idx_q;
                        end else begin
                            first_d = first_q;
                        end
`endif
                    end else begin
                        hit_flag_d = hit_flag_q;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    trial_d   = trial_inc_s;
                    hits_d    = hits_q + {{(CNT_W-1){1'b0}}, hit_flag_q};
                    win_hit_d = hit_flag_q;
`ifdef DET_STAT_FIRST_IDX_EN
                    first_idx_d = first_q;
`endif
                    // Park for good once the trial counter would be all-ones.
                    if (&trial_inc_s) begin
                        sat_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (bus.enable) begin
                        state_d = S_ARM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from the next state so they can be registered.
    always_comb begin
        det_rst_n_d = (state_d == S_RUN);
        busy_d      = (state_d != S_IDLE);
        win_done_d  = (state_d == S_DONE);
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            win_done_q  <= 1'b0;
        end else begin
            det_rst_n_q <= det_rst_n_d;
            busy_q      <= busy_d;
            win_done_q  <= win_done_d;
        end
    end

    assign bus.det_rst_n   = det_rst_n_q;
    assign bus.busy        = busy_q;
    assign bus.win_done    = win_done_q;
    assign bus.win_hit     = win_hit_q;
    assign bus.trial_count = trial_q;
    assign bus.hit_count   = hits_q;
    assign bus.sat         = sat_q;
`ifdef DET_STAT_FIRST_IDX_EN
    assign bus.first_idx   = first_idx_q;
`endif
endmodule

// File: tb/tb_det_stat_window.sv
// -----------------------------------------------------------------------------
// tb_det_stat_window
// Directed bench for det_stat_window: a table of per-window det_in masks with
// hand-computed hit results, plus sequences for enable drop, reset mid-window,
// clear mid-window and saturation (separate CNT_W=4 instance).
// -----------------------------------------------------------------------------
module tb_det_stat_window;
    localparam int WIN_LEN = 9;
    localparam int MIN_IDX = 5;
    localparam int IDX_W   = 4;

    logic clk = 1'b0;
    logic rst_n;

    // 10-unit clock period.
    always #5 clk = ~clk;

`ifdef DET_STAT_FIRST_IDX_EN
    det_stat_window_if #(.CNT_W(32), .IDX_W(IDX_W)) bus  ();
    det_stat_window_if #(.CNT_W(4),  .IDX_W(IDX_W)) sbus ();
`else
    det_stat_window_if #(.CNT_W(32)) bus  ();
    det_stat_window_if #(.CNT_W(4))  sbus ();
`endif

    det_stat_window #(.WIN_LEN(WIN_LEN), .MIN_IDX(MIN_IDX), .CNT_W(32)) u_dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    det_stat_window #(.WIN_LEN(WIN_LEN), .MIN_IDX(MIN_IDX), .CNT_W(4)) u_sat (
        .clk   (clk),
        .reset (rst_n),
        .bus   (sbus)
    );

    typedef struct {
        logic [WIN_LEN:1] mask;      // det_in per window idx (bit k = idx k)
        logic             exp_hit;
        int               exp_first;
    } vec_t;

    vec_t vecs [11];
    int   n_chk   = 0;
    int   n_err   = 0;
    int   trial_m = 0;
    int   hit_m   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called during an ARM cycle of u_dut; returns in the cycle after DONE.
    task automatic run_win(input logic [WIN_LEN:1] mask, input logic exp_hit,
                           input int exp_first, input int drop_at);
        int bad = 0;
        for (int k = 1; k <= WIN_LEN; k++) begin
            @(posedge clk); #1;
            if (bus.win_done !== 1'b0 || bus.det_rst_n !== 1'b1 || bus.busy !== 1'b1) bad++;
            bus.det_in = mask[k];
            if (k == drop_at) bus.enable = 1'b0;
        end
        chk("run_phase_errs", 64'(bad), 64'd0);
        @(posedge clk); #1;
        bus.det_in = 1'b0;
        chk("done_pulse", 64'(bus.win_done), 64'd1);
        chk("done_det_rst_n", 64'(bus.det_rst_n), 64'd0);
        chk("done_busy", 64'(bus.busy), 64'd1);
        trial_m++;
        if (exp_hit) hit_m++;
        @(posedge clk); #1;
        chk("trial_count", 64'(bus.trial_count), 64'(trial_m));
        chk("hit_count", 64'(bus.hit_count), 64'(hit_m));
        chk("win_hit", 64'(bus.win_hit), 64'(exp_hit));
        chk("post_win_done", 64'(bus.win_done), 64'd0);
        chk("post_det_rst_n", 64'(bus.det_rst_n), 64'd0);
        chk("post_busy", 64'(bus.busy), 64'(bus.enable));
`ifdef DET_STAT_FIRST_IDX_EN
        chk("first_idx", 64'(bus.first_idx), 64'(exp_first));
`else
        if (exp_first < 0) $display("note: negative first idx in table");
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int nbusy;

        rst_n        = 1'b0;
        bus.enable   = 1'b0;
        bus.clear    = 1'b0;
        bus.det_in   = 1'b0;
        sbus.enable  = 1'b0;
        sbus.clear   = 1'b0;
        sbus.det_in  = 1'b0;

        vecs[0]  = '{9'b000000000, 1'b0, 0};
        vecs[1]  = '{9'b000000000, 1'b0, 0};
        vecs[2]  = '{9'b000000000, 1'b0, 0};
        vecs[3]  = '{9'b000001000, 1'b0, 0};   // idx 4 only: too early
        vecs[4]  = '{9'b000001000, 1'b0, 0};
        vecs[5]  = '{9'b000010000, 1'b1, 5};   // idx 5: first qualifying
        vecs[6]  = '{9'b100000000, 1'b1, 9};   // idx 9: last cycle
        vecs[7]  = '{9'b000001111, 1'b0, 0};   // idx 1..4
        vecs[8]  = '{9'b111110000, 1'b1, 5};   // idx 5..9 counts once
        vecs[9]  = '{9'b001000001, 1'b1, 7};   // idx 1 and 7
        vecs[10] = '{9'b000100100, 1'b1, 6};   // idx 3 and 6

        // Reset state.
        #12;
        chk("rst_det_rst_n", 64'(bus.det_rst_n), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_win_done", 64'(bus.win_done), 64'd0);
        chk("rst_win_hit", 64'(bus.win_hit), 64'd0);
        chk("rst_trial", 64'(bus.trial_count), 64'd0);
        chk("rst_hits", 64'(bus.hit_count), 64'd0);
        chk("rst_sat", 64'(bus.sat), 64'd0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        @(posedge clk); #1;
        chk("arm_busy", 64'(bus.busy), 64'd1);
        chk("arm_det_rst_n", 64'(bus.det_rst_n), 64'd0);

        // Table of back-to-back windows.
        for (int i = 0; i < 11; i++) begin
            run_win(vecs[i].mask, vecs[i].exp_hit, vecs[i].exp_first, 0);
        end

        // Clear from an ARM cycle.
        bus.enable = 1'b0;
        bus.clear  = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        trial_m = 0;
        hit_m   = 0;
        chk("clr_trial", 64'(bus.trial_count), 64'd0);
        chk("clr_hits", 64'(bus.hit_count), 64'd0);
        chk("clr_win_hit", 64'(bus.win_hit), 64'd0);
        chk("clr_busy", 64'(bus.busy), 64'd0);

        // Enable dropped at idx 6 of window 2: window commits, then idle.
        bus.enable = 1'b1;
        @(posedge clk); #1;
        run_win(9'b000000000, 1'b0, 0, 0);
        run_win(9'b000000000, 1'b0, 0, 6);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_busy", 64'(bus.busy), 64'd0);
        chk("drop_trial", 64'(bus.trial_count), 64'd2);
        chk("drop_det_rst_n", 64'(bus.det_rst_n), 64'd0);

        // Reset at idx 7 with hit_flag already set.
        bus.enable = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            bus.det_in = (k >= 5);
        end
        rst_n = 1'b0;
        #1;
        bus.det_in = 1'b0;
        chk("arst_det_rst_n", 64'(bus.det_rst_n), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_trial", 64'(bus.trial_count), 64'd0);
        chk("arst_hits", 64'(bus.hit_count), 64'd0);
        trial_m = 0;
        hit_m   = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rearm_busy", 64'(bus.busy), 64'd1);
        chk("rearm_det_rst_n", 64'(bus.det_rst_n), 64'd0);
        run_win(9'b000000000, 1'b0, 0, 0);

        // Clear mid-RUN after two committed windows.
        run_win(9'b000010000, 1'b1, 5, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
        end
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        trial_m = 0;
        hit_m   = 0;
        chk("mclr_trial", 64'(bus.trial_count), 64'd0);
        chk("mclr_hits", 64'(bus.hit_count), 64'd0);
        chk("mclr_win_hit", 64'(bus.win_hit), 64'd0);
        chk("mclr_busy", 64'(bus.busy), 64'd0);
        chk("mclr_win_done", 64'(bus.win_done), 64'd0);
        chk("mclr_det_rst_n", 64'(bus.det_rst_n), 64'd0);
        @(posedge clk); #1;
        chk("mclr_arm_busy", 64'(bus.busy), 64'd1);
        chk("mclr_arm_win_done", 64'(bus.win_done), 64'd0);
        run_win(9'b000000000, 1'b0, 0, 0);
        bus.enable = 1'b0;

        // Saturation on the 4-bit instance with det_in always high.
        sbus.det_in = 1'b1;
        sbus.enable = 1'b1;
        nd = 0;
        for (int i = 0; i < 175; i++) begin
            @(posedge clk); #1;
            if (sbus.win_done === 1'b1) nd++;
            if (i == 100) chk("sat_early", 64'(sbus.sat), 64'd0);
        end
        chk("sat_done_pulses", 64'(nd), 64'd15);
        chk("sat_trial", 64'(sbus.trial_count), 64'd15);
        chk("sat_hits", 64'(sbus.hit_count), 64'd15);
        chk("sat_flag", 64'(sbus.sat), 64'd1);
        chk("sat_busy", 64'(sbus.busy), 64'd0);
`ifdef DET_STAT_FIRST_IDX_EN
        chk("sat_first_idx", 64'(sbus.first_idx), 64'd5);
`endif
        nd    = 0;
        nbusy = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (sbus.win_done === 1'b1) nd++;
            if (sbus.busy === 1'b1) nbusy++;
        end
        chk("sat_hold_pulses", 64'(nd), 64'd0);
        chk("sat_hold_busy", 64'(nbusy), 64'd0);
        chk("sat_hold_trial", 64'(sbus.trial_count), 64'd15);
        chk("sat_hold_hits", 64'(sbus.hit_count), 64'd15);
        chk("sat_hold_flag", 64'(sbus.sat), 64'd1);
        sbus.clear = 1'b1;
        @(posedge clk); #1;
        sbus.clear  = 1'b0;
        sbus.enable = 1'b0;
        chk("sat_clr_flag", 64'(sbus.sat), 64'd0);
        chk("sat_clr_trial", 64'(sbus.trial_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
